// File: rtl/value_sweep_ctrl_pkg.sv
// Shared types for the backward-induction sweep controller, value memory bank and datapath.
package value_sweep_ctrl_pkg;
  localparam int ADDR_W = 10;
  localparam int LAT_W  = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LAT_W-1:0]  lat_cnt_t;

  localparam addr_t ADDR_ONE = addr_t'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_INIT,
    ST_SWEEP,
    ST_DRAIN,
    ST_FIN
  } sweep_state_t;

  // Drain counter counts down to zero, so it is loaded with one less than the latency.
  function automatic lat_cnt_t drain_load(input int lat);
    return lat_cnt_t'(lat - 1);
  endfunction
endpackage

// File: rtl/sweep_delay_line.sv
// Fixed-depth shift register that re-times the read strobe/address into the write-back strobe/address.
module sweep_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/value_sweep_ctrl.sv
// Sequences one pricing run: zero-fill the value bank, then sweep steps N..1, reading nodes 0..s-1 per step.
//   state     | meaning
//   IDLE      | waiting for start
//   INIT      | one-cycle zero-fill request
//   WAIT_INIT | waiting for the bank to finish zero-fill
//   SWEEP     | issuing node reads j = 0..s-1
//   DRAIN     | LAT cycles letting step s write-backs land
//   FIN       | done pulse, back to IDLE
module value_sweep_ctrl
  import value_sweep_ctrl_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_steps,
  input  logic              done_init,
  output logic              start_init,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] wraddr,
  output logic              wren,
  output logic [ADDR_W-1:0] step,
  output logic              busy,
  output logic              done
);

  sweep_state_t state;
  addr_t        n_lat;
  lat_cnt_t     drain_cnt;
  logic [ADDR_W:0] dl_out;

  // rdaddr doubles as the node counter j and step as the step counter s.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      n_lat      <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_init <= 1'b0;
      rd_valid   <= 1'b0;
      rdaddr     <= '0;
      step       <= '0;
    end else begin
      start_init <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat      <= num_steps;
            busy       <= 1'b1;
            start_init <= 1'b1;
            state      <= ST_INIT;
          end
        end
        ST_INIT: state <= ST_WAIT_INIT;
        ST_WAIT_INIT: begin
          if (done_init) begin
            if (n_lat == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end else begin
              step     <= n_lat;
              rdaddr   <= '0;
              rd_valid <= 1'b1;
              state    <= ST_SWEEP;
            end
          end
        end
        ST_SWEEP: begin
          if (rdaddr == step - ADDR_ONE) begin
            rd_valid  <= 1'b0;
            drain_cnt <= drain_load(LAT);
            state     <= ST_DRAIN;
          end else begin
            rdaddr <= rdaddr + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            if (step == ADDR_ONE) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end else begin
              step     <= step - ADDR_ONE;
              rdaddr   <= '0;
              rd_valid <= 1'b1;
              state    <= ST_SWEEP;
            end
          end else begin
            drain_cnt <= drain_cnt - lat_cnt_t'(1);
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sweep_delay_line #(
    .DEPTH(LAT),
    .WIDTH(ADDR_W + 1)
  ) u_delay (
    .clk (clk),
    .nrst(nrst),
    .din ({rd_valid, rdaddr}),
    .dout(dl_out)
  );

  assign wren   = dl_out[ADDR_W];
  assign wraddr = dl_out[ADDR_W-1:0];

endmodule

// File: tb/tb_value_sweep_ctrl.sv
// Directed bench for value_sweep_ctrl with a LAT=2 and a LAT=15 instance sharing inputs.
module tb_value_sweep_ctrl;

  localparam int LAT_A = 2;
  localparam int LAT_B = 15;
  localparam int MAXC  = 2200;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       done_init = 1'b0;
  logic [9:0] num_steps = '0;
  logic       sel = 1'b0;

  logic       start_init_a, rd_valid_a, wren_a, busy_a, done_a;
  logic [9:0] rdaddr_a, wraddr_a, step_a;
  logic       start_init_b, rd_valid_b, wren_b, busy_b, done_b;
  logic [9:0] rdaddr_b, wraddr_b, step_b;

  logic       m_start_init, m_rv, m_wren, m_busy, m_done;
  logic [9:0] m_rdaddr, m_wraddr, m_step;

  int checks = 0;
  int errors = 0;
  int e_rv [MAXC];
  int e_ra [MAXC];
  int e_st [MAXC];

  always #5 clk = ~clk;

  value_sweep_ctrl #(.LAT(LAT_A)) dut_a (
    .clk(clk), .nrst(nrst), .start(start), .num_steps(num_steps), .done_init(done_init),
    .start_init(start_init_a), .rdaddr(rdaddr_a), .rd_valid(rd_valid_a), .wraddr(wraddr_a),
    .wren(wren_a), .step(step_a), .busy(busy_a), .done(done_a)
  );

  value_sweep_ctrl #(.LAT(LAT_B)) dut_b (
    .clk(clk), .nrst(nrst), .start(start), .num_steps(num_steps), .done_init(done_init),
    .start_init(start_init_b), .rdaddr(rdaddr_b), .rd_valid(rd_valid_b), .wraddr(wraddr_b),
    .wren(wren_b), .step(step_b), .busy(busy_b), .done(done_b)
  );

  assign m_start_init = sel ? start_init_b : start_init_a;
  assign m_rv         = sel ? rd_valid_b   : rd_valid_a;
  assign m_wren       = sel ? wren_b       : wren_a;
  assign m_busy       = sel ? busy_b       : busy_a;
  assign m_done       = sel ? done_b       : done_a;
  assign m_rdaddr     = sel ? rdaddr_b     : rdaddr_a;
  assign m_wraddr     = sel ? wraddr_b     : wraddr_a;
  assign m_step       = sel ? step_b       : step_a;

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; start = 1'b0; done_init = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({m_busy, m_done, m_start_init, m_rv, m_wren} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d got %b exp 00000", s, {m_busy, m_done, m_start_init, m_rv, m_wren});
      end
      checks++;
      if ({m_rdaddr, m_wraddr, m_step} !== 30'b0) begin
        errors++;
        $display("FAIL reset_addr dut%0d got %h exp 0", s, {m_rdaddr, m_wraddr, m_step});
      end
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // Runs one start..done sequence and compares every cycle against a step-by-step sequence model.
  task automatic run_sweep(input string name, input bit s_sel, input int n, input bit with_reset,
                           input bit repulse, input int window, input int exp_writes,
                           input int exp_done_c, input int exp_max);
    int lat, c, writes, dones, max_a, wi;
    bit exp_w;
    lat = s_sel ? LAT_B : LAT_A;
    sel = s_sel;
    if (with_reset) do_reset();
    c = 0;
    for (int s = n; s >= 1 && c < MAXC; s--) begin
      for (int j = 0; j < s && c < MAXC; j++) begin
        e_rv[c] = 1; e_ra[c] = j; e_st[c] = s; c++;
      end
      for (int d = 0; d < lat && c < MAXC; d++) begin
        e_rv[c] = 0; e_ra[c] = 0; e_st[c] = s; c++;
      end
    end
    for (int k = c; k < MAXC; k++) begin
      e_rv[k] = 0; e_ra[k] = 0; e_st[k] = 1;
    end
    start = 1'b1; num_steps = n[9:0];
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({m_start_init, m_busy, m_rv} !== 3'b110) begin
      errors++;
      $display("FAIL %s_init got %b exp 110", name, {m_start_init, m_busy, m_rv});
    end
    @(negedge clk);
    checks++;
    if ({m_start_init, m_busy, m_rv} !== 3'b010) begin
      errors++;
      $display("FAIL %s_wait_init got %b exp 010", name, {m_start_init, m_busy, m_rv});
    end
    done_init = 1'b1;
    @(negedge clk);
    done_init = 1'b0;
    writes = 0; dones = 0; max_a = 0;
    for (c = 0; c < window; c++) begin
      checks++;
      if (m_rv !== (e_rv[c] != 0)) begin
        errors++;
        $display("FAIL %s_rd_valid c=%0d got %b exp %0d", name, c, m_rv, e_rv[c]);
      end
      if (e_rv[c] != 0) begin
        checks++;
        if (m_rdaddr !== 10'(e_ra[c])) begin
          errors++;
          $display("FAIL %s_rdaddr c=%0d got %0d exp %0d", name, c, m_rdaddr, e_ra[c]);
        end
      end
      checks++;
      if (m_step !== 10'(e_st[c])) begin
        errors++;
        $display("FAIL %s_step c=%0d got %0d exp %0d", name, c, m_step, e_st[c]);
      end
      wi = c - lat;
      exp_w = (wi >= 0) ? (e_rv[wi] != 0) : 1'b0;
      checks++;
      if (m_wren !== exp_w) begin
        errors++;
        $display("FAIL %s_wren c=%0d got %b exp %b", name, c, m_wren, exp_w);
      end
      if (exp_w) begin
        checks++;
        if (m_wraddr !== 10'(e_ra[wi])) begin
          errors++;
          $display("FAIL %s_wraddr c=%0d got %0d exp %0d", name, c, m_wraddr, e_ra[wi]);
        end
      end
      checks++;
      if (m_done !== (c == exp_done_c)) begin
        errors++;
        $display("FAIL %s_done c=%0d got %b exp %b", name, c, m_done, (c == exp_done_c));
      end
      checks++;
      if (m_busy !== (exp_done_c < 0 || c < exp_done_c)) begin
        errors++;
        $display("FAIL %s_busy c=%0d got %b exp %b", name, c, m_busy, (exp_done_c < 0 || c < exp_done_c));
      end
      if (m_wren === 1'b1) writes++;
      if (m_done === 1'b1) dones++;
      if (m_wren === 1'b1 && int'(m_wraddr) > max_a) max_a = int'(m_wraddr);
      if (m_rv === 1'b1 && int'(m_rdaddr) > max_a) max_a = int'(m_rdaddr);
      start     = repulse && c == 1;
      num_steps = (repulse && c == 1) ? 10'd7 : n[9:0];
      done_init = repulse && c == 3;
      @(negedge clk);
    end
    start = 1'b0; done_init = 1'b0;
    checks++;
    if (writes != exp_writes) begin
      errors++;
      $display("FAIL %s_write_count got %0d exp %0d", name, writes, exp_writes);
    end
    checks++;
    if (dones != ((exp_done_c >= 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_done_count got %0d exp %0d", name, dones, (exp_done_c >= 0) ? 1 : 0);
    end
    checks++;
    if (max_a != exp_max) begin
      errors++;
      $display("FAIL %s_max_addr got %0d exp %0d", name, max_a, exp_max);
    end
  endtask

  task automatic test_sweep_n3();
    // reads 0,1,2 | 0,1 | 0 with 2-cycle drains: done at cycle 12, six writes
    run_sweep("n3", 1'b0, 3, 1'b1, 1'b0, 16, 6, 12, 2);
  endtask

  task automatic test_n0();
    do_reset();
    sel = 1'b0;
    start = 1'b1; num_steps = 10'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({m_start_init, m_busy} !== 2'b11) begin
      errors++;
      $display("FAIL n0_init got %b exp 11", {m_start_init, m_busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m_start_init, m_busy, m_rv, m_done} !== 4'b0100) begin
        errors++;
        $display("FAIL n0_wait cyc=%0d got %b exp 0100", i, {m_start_init, m_busy, m_rv, m_done});
      end
    end
    done_init = 1'b1;
    @(negedge clk);
    done_init = 1'b0;
    checks++;
    if ({m_done, m_busy, m_rv, m_wren} !== 4'b1000) begin
      errors++;
      $display("FAIL n0_fin got %b exp 1000", {m_done, m_busy, m_rv, m_wren});
    end
    @(negedge clk);
    checks++;
    if ({m_done, m_busy, m_rv, m_wren} !== 4'b0000) begin
      errors++;
      $display("FAIL n0_idle got %b exp 0000", {m_done, m_busy, m_rv, m_wren});
    end
  endtask

  task automatic test_idle_done_init();
    do_reset();
    sel = 1'b0;
    done_init = 1'b1;
    @(negedge clk);
    done_init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({m_busy, m_start_init, m_done, m_rv} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_done_init cyc=%0d got %b exp 0000", i, {m_busy, m_start_init, m_done, m_rv});
      end
      @(negedge clk);
    end
    start = 1'b1; num_steps = 10'd2;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({m_start_init, m_busy} !== 2'b11) begin
      errors++;
      $display("FAIL idle_then_init got %b exp 11", {m_start_init, m_busy});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m_rv, m_busy} !== 2'b01) begin
        errors++;
        $display("FAIL idle_then_wait cyc=%0d got %b exp 01", i, {m_rv, m_busy});
      end
    end
    done_init = 1'b1;
    @(negedge clk);
    done_init = 1'b0;
    checks++;
    if ({m_rv, m_rdaddr, m_step} !== {1'b1, 10'd0, 10'd2}) begin
      errors++;
      $display("FAIL idle_then_sweep got %b/%0d/%0d exp 1/0/2", m_rv, m_rdaddr, m_step);
    end
  endtask

  task automatic test_restart();
    // start and done_init re-pulsed mid-run must leave the N=3 trace untouched
    run_sweep("restart", 1'b0, 3, 1'b1, 1'b1, 20, 6, 12, 2);
  endtask

  task automatic test_reset_mid();
    int wr;
    do_reset();
    sel = 1'b0;
    start = 1'b1; num_steps = 10'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    done_init = 1'b1;
    @(negedge clk);
    done_init = 1'b0;
    repeat (9) @(negedge clk);
    // cycle 9: third read of step s=4, write of node 0 in flight
    checks++;
    if ({m_rv, m_wren, m_rdaddr, m_step} !== {1'b1, 1'b1, 10'd2, 10'd4}) begin
      errors++;
      $display("FAIL mid_pre got %b/%b/%0d/%0d exp 1/1/2/4", m_rv, m_wren, m_rdaddr, m_step);
    end
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({m_busy, m_done, m_start_init, m_rv, m_wren} !== 5'b0) begin
      errors++;
      $display("FAIL mid_async_ctrl got %b exp 00000", {m_busy, m_done, m_start_init, m_rv, m_wren});
    end
    checks++;
    if ({m_rdaddr, m_wraddr, m_step} !== 30'b0) begin
      errors++;
      $display("FAIL mid_async_addr got %h exp 0", {m_rdaddr, m_wraddr, m_step});
    end
    @(negedge clk);
    nrst = 1'b1;
    wr = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({m_wren, m_rv, m_busy} !== 3'b000) begin
        errors++;
        $display("FAIL mid_after_release cyc=%0d got %b exp 000", i, {m_wren, m_rv, m_busy});
      end
      if (m_wren === 1'b1) wr++;
      @(negedge clk);
    end
    checks++;
    if (wr != 0) begin
      errors++;
      $display("FAIL mid_stale_writes got %0d exp 0", wr);
    end
    run_sweep("n2_after_reset", 1'b0, 2, 1'b0, 1'b0, 10, 3, 7, 1);
  endtask

  task automatic test_big();
    // first two steps of N=1023 at LAT=15: 1023+1022 reads, all written back by cycle 2074
    run_sweep("n1023", 1'b1, 1023, 1'b1, 1'b0, 2076, 2045, -1, 1022);
    // complete N=40 run at LAT=15: 40*41/2 = 820 writes, done after 820 + 40*15 cycles
    run_sweep("n40_lat15", 1'b1, 40, 1'b1, 1'b0, 1424, 820, 1420, 39);
  endtask

  initial begin
    test_reset();
    test_sweep_n3();
    test_n0();
    test_idle_done_init();
    test_restart();
    test_reset_mid();
    test_big();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
